instruction_encoder: RTL

- Inverse of the CPU's instruction decode stage. Accepts one instruction request per handshake: a type index plus register, shift and immediate fields.
- Emits the 32-bit MIPS machine word, tagged with a sequential word address.
- Used by the test/boot loader path to fill instruction memory.
- Contains a registered output stage with a one-entry skid buffer, an address counter, and a sticky illegal-type error.

---
 rtl/instruction_encoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: turns a (type index, field) request into a 32-bit MIPS
// machine word tagged with a sequential word address. Registered output stage
// backed by a one-entry skid buffer so in_ready never depends on out_ready.
module instruction_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_type,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  fmt_t              fmt;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        f_rs;
  logic [4:0]        f_rt;
  logic [4:0]        f_rd;
  logic [4:0]        f_sh;
  logic              enc_legal;
  logic [31:0]       enc_word;

  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_addr;
  logic [ADDR_W-1:0] addr_cnt;

  logic              accept;
  logic              take;
  logic              out_free;
  logic              load_skid;

  // Decode the type index into opcode/funct and mask fields the format ignores.
  // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
  always_comb begin
    fmt       = FMT_R;
    op        = 6'h00;
    funct     = 6'h00;
    f_rs      = in_rs;
    f_rt      = in_rt;
    f_rd      = in_rd;
    f_sh      = 5'd0;
    enc_legal = 1'b1;
    case (in_type)
      5'd0:  funct = 6'h20;                        // add
      5'd3:  funct = 6'h21;                        // addu
      5'd4:  funct = 6'h24;                        // and
      5'd9:  funct = 6'h22;                        // sub
      5'd10: funct = 6'h25;                        // or
      5'd12: funct = 6'h27;                        // nor
      5'd17: funct = 6'h2A;                        // slt
      5'd19: funct = 6'h2B;                        // sltu
      5'd6:  begin funct = 6'h00; f_rs = '0; f_sh = in_shamt; end  // sll
      5'd7:  begin funct = 6'h03; f_rs = '0; f_sh = in_shamt; end  // sra
      5'd8:  begin funct = 6'h02; f_rs = '0; f_sh = in_shamt; end  // srl
      5'd22: begin funct = 6'h08; f_rt = '0; f_rd = '0; end        // jr
      5'd23: begin funct = 6'h0C; f_rs = '0; f_rt = '0; f_rd = '0; end  // syscall
      5'd24: begin funct = 6'h1B; f_rd = '0; end                   // divu
      5'd25: begin funct = 6'h12; f_rs = '0; f_rt = '0; end        // mflo
      5'd1:  begin fmt = FMT_I; op = 6'h08; end    // addi
      5'd2:  begin fmt = FMT_I; op = 6'h09; end    // addiu
      5'd5:  begin fmt = FMT_I; op = 6'h0C; end    // andi
      5'd11: begin fmt = FMT_I; op = 6'h0D; end    // ori
      5'd13: begin fmt = FMT_I; op = 6'h23; end    // lw
      5'd14: begin fmt = FMT_I; op = 6'h2B; end    // sw
      5'd15: begin fmt = FMT_I; op = 6'h04; end    // beq
      5'd16: begin fmt = FMT_I; op = 6'h05; end    // bne
      5'd18: begin fmt = FMT_I; op = 6'h0A; end    // slti
      5'd26: begin fmt = FMT_I; op = 6'h20; end    // lb
      5'd27: begin fmt = FMT_I; op = 6'h07; f_rt = '0; end  // bgtz
      5'd20: begin fmt = FMT_J; op = 6'h02; end    // j
      5'd21: begin fmt = FMT_J; op = 6'h03; end    // jal
      default: enc_legal = 1'b0;
    endcase
  end

  // Assemble the machine word from the masked fields.
  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R:   enc_word = {op, f_rs, f_rt, f_rd, f_sh, funct};
      FMT_I:   enc_word = {op, f_rs, f_rt, in_imm[15:0]};
      FMT_J:   enc_word = {op, in_imm};
      default: enc_word = '0;
    endcase
  end

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign take      = accept && enc_legal && !clear;
  assign out_free  = !out_valid || out_ready;
  assign load_skid = take && !out_free;

  // Control state: output stage, skid occupancy, address counter, count, error.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE;
      skid_valid <= 1'b0;
      addr_cnt   <= BASE;
      count      <= '0;
      err        <= 1'b0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE;
      skid_valid <= 1'b0;
      addr_cnt   <= BASE;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      if (out_valid && out_ready) count    <= count + 1'b1;
      if (accept && !enc_legal)   err      <= 1'b1;
      if (take)                   addr_cnt <= addr_cnt + 1'b1;
      if (out_free) begin
        // Skid entry is older than anything arriving now, so it drains first.
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= skid_instr;
          out_addr   <= skid_addr;
          skid_valid <= 1'b0;
        end else if (take) begin
          out_valid <= 1'b1;
          out_instr <= enc_word;
          out_addr  <= addr_cnt;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (take) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // Skid payload capture.
  // NOTE: payload registers carry no reset; skid_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_instr <= enc_word;
      skid_addr  <= addr_cnt;
    end
  end

endmodule
